// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types for the fetch/MEM-stage memory arbiter: FSM state
//            encoding, grant encoding and latency-counter width.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Wide enough for the largest legal access time (15 cycles).
  localparam int unsigned CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_lat_counter.sv
`default_nettype none
// ============================================================================
// Module   : lat_counter
// Brief    : Loadable down-counter timing a backing-memory access; reports
//            when it has reached zero.
// Revision : 1.0 - initial release
// ============================================================================
module lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates a fetch port and a MEM-stage port onto one fixed-
//            latency backing memory. One access at a time, alternating grant
//            on contention, one-cycle response strobe per access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [AW-1:0] i_rdata,
  output logic          i_valid,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] d_wdata,
  output logic [AW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic [AW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  arb_state_t    state_q, state_d;
  grant_t        grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] i_rdata_q, i_rdata_d;
  logic [AW-1:0] d_rdata_q, d_rdata_d;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;
  logic          busy;

  lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state logic: accept/arbitrate in IDLE, time the access, respond.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // D wins unless it had the previous grant and I is also waiting.
        if (d_req && (!i_req || (grant_q != GRANT_D))) begin
          state_d  = ST_D_BUSY;
          grant_d  = GRANT_D;
          addr_d   = d_addr;
          wr_d     = d_wr;
          wdata_d  = d_wdata;
          cnt_load = 1'b1;
        end else if (i_req) begin
          state_d  = ST_I_BUSY;
          grant_d  = GRANT_I;
          addr_d   = i_addr;
          wr_d     = 1'b0;
          wdata_d  = '0;
          cnt_load = 1'b1;
        end
      end
      ST_I_BUSY: begin
        if (cnt_zero) begin
          i_rdata_d = mem_rdata;
          state_d   = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_D_BUSY: begin
        if (cnt_zero) begin
          if (!wr_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured request and returned-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= GRANT_I;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Memory bus is only driven while an access is in flight.
  assign busy      = (state_q == ST_I_BUSY) || (state_q == ST_D_BUSY);
  assign mem_en    = busy;
  assign mem_wr    = (state_q == ST_D_BUSY) && wr_q;
  assign mem_addr  = busy ? addr_q  : '0;
  assign mem_wdata = busy ? wdata_q : '0;

  assign i_valid   = (state_q == ST_RESP) && (grant_q == GRANT_I);
  assign d_valid   = (state_q == ST_RESP) && (grant_q == GRANT_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire
